// File: rtl/decoder_nx_seq_pkg.sv
// Shared mode constants, state encoding and the {en, mode} -> state mapping.
package decoder_pkg;

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_THERMO = 3'd2,
    ST_SCAN   = 3'd3,
    ST_RSVD   = 3'd4
  } state_e;

  // The state follows the live inputs one cycle later; en has priority.
  function automatic state_e mode2state(input logic en, input logic [1:0] mode);
    if (!en) return ST_IDLE;
    case (mode)
      MODE_DECODE: return ST_DECODE;
      MODE_THERMO: return ST_THERMO;
      MODE_SCAN:   return ST_SCAN;
      default:     return ST_RSVD;
    endcase
  endfunction

endpackage

// File: rtl/decoder_nx_seq_if.sv
// Control/select bus of the decoder. master = control logic, slave = decoder.
interface decoder_nx_seq_if #(parameter int N = 3);
  localparam int OUT_W = 1 << N;

  logic             en;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     sel;
  logic [OUT_W-1:0] d;
  logic             d_valid;
  logic [N-1:0]     scan_idx;
  logic             wrap;

  modport master (
    output en, mode, in_valid, sel,
    input  in_ready, d, d_valid, scan_idx, wrap
  );

  modport slave (
    input  en, mode, in_valid, sel,
    output in_ready, d, d_valid, scan_idx, wrap
  );
endinterface

// File: rtl/decoder_nx_seq_scan_timer.sv
// Scan index generator: each index held SCAN_DIV cycles, wrap pulse on roll-over.
module scan_timer #(
  parameter int N        = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         run,
  output logic [N-1:0] idx,
  output logic [N-1:0] idx_nxt,
  output logic         wrap
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [N-1:0]     r_idx;
  logic             r_wrap, w_wrap_nxt, w_tc;

  // Next divider/index/wrap; idx_nxt is exported so the owner can register
  // a pattern that lines up with idx in the same cycle.
  always_comb begin
    w_tc       = (r_div == DIV_TC);
    w_div_nxt  = r_div;
    idx_nxt    = r_idx;
    w_wrap_nxt = 1'b0;
    if (clear) begin
      w_div_nxt = '0;
      idx_nxt   = '0;
    end else if (run) begin
      if (w_tc) begin
        w_div_nxt  = '0;
        idx_nxt    = r_idx + 1'b1;
        w_wrap_nxt = (r_idx == '1);
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end
  end

  // Timer state; async reset drops everything, including a pending wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_idx  <= idx_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign idx  = r_idx;
  assign wrap = r_wrap;
endmodule

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N decoder with one-hot, thermometer and self-timed scan modes.
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int ACTIVE_LOW = 0,
  parameter int SCAN_DIV   = 4
) (
  input logic               clk,
  input logic               rst_n,
  decoder_nx_seq_if.slave   bus
);
  localparam int OUT_W = 1 << N;
  localparam logic [OUT_W-1:0] INACT = (ACTIVE_LOW != 0) ? '1 : '0;

  state_e           r_state, w_nstate;
  logic [N-1:0]     r_sel, w_sel_nxt;
  logic             r_have, w_have_nxt;
  logic [OUT_W-1:0] r_d, w_pat, w_hot, w_thr, w_scn;
  logic             r_dv, w_dv_nxt;
  logic             w_rdy, w_cap, w_park;
  logic             w_scan_clr, w_scan_run;
  logic [N-1:0]     w_idx, w_idx_nxt;
  logic             w_wrap;

  // Ready depends only on the live en/mode, never on in_valid.
  assign w_rdy = bus.en & ~bus.mode[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // Next state straight from {en, mode}.
  always_comb w_nstate = mode2state(bus.en, bus.mode);

  // Output decode: capture, held-select validity and the pattern for the next cycle.
  always_comb begin
    w_cap      = bus.in_valid & w_rdy;
    w_park     = (w_nstate == ST_IDLE) || (w_nstate == ST_RSVD);
    w_sel_nxt  = w_cap ? bus.sel : r_sel;
    // A held select only counts once captured since the last IDLE/RSVD stay.
    w_have_nxt = w_cap | (r_have & ~w_park);
    for (int k = 0; k < OUT_W; k++) begin
      w_hot[k] = (w_sel_nxt == N'(k));
      w_thr[k] = (N'(k) <= w_sel_nxt);
      w_scn[k] = (w_idx_nxt == N'(k));
    end
    w_pat    = '0;
    w_dv_nxt = 1'b0;
    case (w_nstate)
      ST_DECODE: begin w_pat = w_have_nxt ? w_hot : '0; w_dv_nxt = w_have_nxt; end
      ST_THERMO: begin w_pat = w_have_nxt ? w_thr : '0; w_dv_nxt = w_have_nxt; end
      ST_SCAN:   begin w_pat = w_scn;                   w_dv_nxt = 1'b1;       end
      default:   ;
    endcase
    // Clearing on entry as well as outside SCAN makes the first SCAN cycle show index 0.
    w_scan_run = (w_nstate == ST_SCAN);
    w_scan_clr = !w_scan_run || (r_state != ST_SCAN);
  end

  // Output/data registers; polarity is folded in ahead of the flop so d never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_have <= 1'b0;
      r_d    <= INACT;
      r_dv   <= 1'b0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_have <= w_have_nxt;
      r_d    <= w_pat ^ INACT;
      r_dv   <= w_dv_nxt;
    end
  end

  scan_timer #(.N(N), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_scan_clr),
    .run     (w_scan_run),
    .idx     (w_idx),
    .idx_nxt (w_idx_nxt),
    .wrap    (w_wrap)
  );

  assign bus.in_ready = w_rdy;
  assign bus.d        = r_d;
  assign bus.d_valid  = r_dv;
  assign bus.scan_idx = w_idx;
  assign bus.wrap     = w_wrap;
endmodule

// File: tb/tb_decoder_nx_seq.sv
// Bench for decoder_nx_seq: two instances (active-high/div 4, active-low/div 1)
// share stimulus and are compared every cycle against a behavioural model.
module tb_decoder_nx_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic [2:0] sel = 3'd0;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  decoder_nx_seq_if #(.N(3)) if0 ();
  decoder_nx_seq_if #(.N(3)) if1 ();

  assign if0.en = en;       assign if1.en = en;
  assign if0.mode = mode;   assign if1.mode = mode;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.sel = sel;     assign if1.sel = sel;

  decoder_nx_seq #(.N(3), .ACTIVE_LOW(0), .SCAN_DIV(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  decoder_nx_seq #(.N(3), .ACTIVE_LOW(1), .SCAN_DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Behavioural model. Category: 0 decode, 1 thermo, 2 scan, 3 reserved, 4 idle.
  int       m_cat = 4;
  bit       m_have = 1'b0;
  int       m_sel = 0;
  int       m_cnt = 0;   // cycles spent in SCAN since entry

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cat <= 4; m_have <= 1'b0; m_sel <= 0; m_cnt <= 0;
    end else begin
      automatic int c = en ? int'(mode) : 4;
      m_cat <= c;
      if (in_valid && en && !mode[1]) begin
        m_sel <= int'(sel); m_have <= 1'b1;
      end else if (c >= 3) m_have <= 1'b0;
      m_cnt <= (c == 2 && m_cat == 2) ? m_cnt + 1 : 0;
    end
  end

  function automatic logic [7:0] exp_d(bit al, int div);
    logic [7:0] p = 8'h00;
    if (m_cat == 2) p = 8'd1 << ((m_cnt / div) % 8);
    else if (m_cat == 0 && m_have) p = 8'd1 << m_sel;
    else if (m_cat == 1 && m_have) p = 8'((16'd2 << m_sel) - 16'd1);
    return al ? ~p : p;
  endfunction

  function automatic logic [2:0] exp_idx(int div);
    return (m_cat == 2) ? 3'((m_cnt / div) % 8) : 3'd0;
  endfunction

  function automatic logic exp_wrap(int div);
    return (m_cat == 2) && (m_cnt > 0) && (m_cnt % (div * 8) == 0);
  endfunction

  function automatic logic exp_dv();
    return (m_cat == 2) || (m_cat < 2 && m_have);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("u0.d",        64'(if0.d),        64'(exp_d(1'b0, 4)));
      chk("u0.d_valid",  64'(if0.d_valid),  64'(exp_dv()));
      chk("u0.scan_idx", 64'(if0.scan_idx), 64'(exp_idx(4)));
      chk("u0.wrap",     64'(if0.wrap),     64'(exp_wrap(4)));
      chk("u0.in_ready", 64'(if0.in_ready), 64'(en && !mode[1]));
      chk("u1.d",        64'(if1.d),        64'(exp_d(1'b1, 1)));
      chk("u1.d_valid",  64'(if1.d_valid),  64'(exp_dv()));
      chk("u1.scan_idx", 64'(if1.scan_idx), 64'(exp_idx(1)));
      chk("u1.wrap",     64'(if1.wrap),     64'(exp_wrap(1)));
      chk("u1.in_ready", 64'(if1.in_ready), 64'(en && !mode[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wcnt;
    int wat;
    // Reset state.
    repeat (3) tick();
    chk_on = 1'b1;
    chk("rst u0.d", 64'(if0.d), 64'h00);
    chk("rst u1.d", 64'(if1.d), 64'hFF);
    chk("rst u0.d_valid", 64'(if0.d_valid), 64'd0);
    rst_n = 1'b1;

    // 1: decode sel 5, then hold.
    en = 1'b1; mode = 2'b00; sel = 3'd5; in_valid = 1'b1;
    tick();
    chk("t1 u0.d", 64'(if0.d), 64'h20);
    chk("t1 u0.d_valid", 64'(if0.d_valid), 64'd1);
    chk("t1 u1.d", 64'(if1.d), 64'hDF);
    in_valid = 1'b0; sel = 3'd2;
    tick();
    chk("t1 hold", 64'(if0.d), 64'h20);

    // 2: decode 3, switch to thermo, then 7 and 0.
    sel = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mode = 2'b01;
    tick();
    chk("t2 thermo3", 64'(if0.d), 64'h0F);
    chk("t2 dv", 64'(if0.d_valid), 64'd1);
    sel = 3'd7; in_valid = 1'b1;
    tick();
    chk("t2 thermo7", 64'(if0.d), 64'hFF);
    sel = 3'd0;
    tick();
    chk("t2 thermo0", 64'(if0.d), 64'h01);
    in_valid = 1'b0;

    // 4: active-low decode of 2, then drop en.
    mode = 2'b00; sel = 3'd2; in_valid = 1'b1;
    tick();
    chk("t4 u1.d", 64'(if1.d), 64'hFB);
    in_valid = 1'b0; en = 1'b0;
    #1 chk("t4 in_ready", 64'(if1.in_ready), 64'd0);
    tick();
    chk("t4 u1.d idle", 64'(if1.d), 64'hFF);
    chk("t4 u1.dv idle", 64'(if1.d_valid), 64'd0);

    // 3: scan with divider 4; sel/in_valid must be ignored.
    en = 1'b1; mode = 2'b10; sel = 3'd6; in_valid = 1'b1;
    #1 chk("t3 in_ready", 64'(if0.in_ready), 64'd0);
    tick();
    wcnt = 0; wat = -1;
    for (int i = 0; i <= 32; i++) begin
      if (if0.wrap) begin wcnt++; wat = i; end
      if (i == 0)  chk("t3 d@0",  64'(if0.d), 64'h01);
      if (i == 4)  chk("t3 d@4",  64'(if0.d), 64'h02);
      if (i == 28) chk("t3 d@28", 64'(if0.d), 64'h80);
      if (i == 32) chk("t3 d@32", 64'(if0.d), 64'h01);
      if (i < 32) tick();
    end
    chk("t3 wrap count", 64'(wcnt), 64'd1);
    chk("t3 wrap cycle", 64'(wat), 64'd32);
    in_valid = 1'b0;

    // 5: async reset mid-scan at index 6.
    en = 1'b0;
    tick();
    en = 1'b1; mode = 2'b10;
    repeat (25) tick();
    chk("t5 idx before rst", 64'(if0.scan_idx), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 rst d", 64'(if0.d), 64'h00);
    chk("t5 rst idx", 64'(if0.scan_idx), 64'd0);
    chk("t5 rst wrap", 64'(if0.wrap), 64'd0);
    chk("t5 rst dv", 64'(if0.d_valid), 64'd0);
    chk("t5 rst u1.d", 64'(if1.d), 64'hFF);
    tick(); tick();
    rst_n = 1'b1; mode = 2'b00;
    tick();
    chk("t5 no capture dv", 64'(if0.d_valid), 64'd0);
    sel = 3'd4; in_valid = 1'b1;
    tick();
    chk("t5 capture d", 64'(if0.d), 64'h10);
    chk("t5 capture dv", 64'(if0.d_valid), 64'd1);
    in_valid = 1'b0;

    // 6: reserved mode, then decode needs a fresh capture.
    mode = 2'b11;
    #1 chk("t6 in_ready", 64'(if0.in_ready), 64'd0);
    tick();
    chk("t6 d", 64'(if0.d), 64'h00);
    chk("t6 dv", 64'(if0.d_valid), 64'd0);
    mode = 2'b00;
    tick(); tick();
    chk("t6 dv stays 0", 64'(if0.d_valid), 64'd0);
    sel = 3'd1; in_valid = 1'b1;
    tick();
    chk("t6 d", 64'(if0.d), 64'h02);
    in_valid = 1'b0;

    // Random traffic with sticky modes so scans run long enough to wrap.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      in_valid = ($urandom_range(0, 2) == 0);
      sel = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/decoder_nx_seq.md
Name: decoder_nx_seq

Overview:
Parametrised, registered N-to-2^N decoder. It is the successor to the fixed 3-to-8 combinational decoder.
- Adds a valid/ready capture handshake, a thermometer mode and a self-timed scan mode for strobing digit and row selects.
- Provides selectable output polarity and glitch-free registered outputs.
- Sits between control logic and select-driven loads such as display digits, memory bank enables and mux selects.

Parameters:
N, 3, select width; output width OUT_W = 2**N (localparam, not overridable); legal range 1..6
ACTIVE_LOW, 0, 0: asserted output bit = 1; 1: all output bits inverted (inactive = all ones)
SCAN_DIV, 4, clock cycles per scan step in SCAN mode; legal range >= 1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 forces outputs inactive
mode  input  2  00 DECODE, 01 THERMO, 10 SCAN, 11 reserved
in_valid  input  1  sel is valid this cycle
in_ready  output  1  block accepts sel this cycle
sel  input  N  select index
d  output  OUT_W  decoded output, registered, polarity per ACTIVE_LOW
d_valid  output  1  d holds a meaningful pattern
scan_idx  output  N  current scan index; 0 outside SCAN
wrap  output  1  one-cycle pulse when scan_idx wraps from OUT_W-1 to 0

Behaviour:
- Reset (async assert, sync-safe deassert to the clk edge):
  - d = inactive (all 0, or all 1 if ACTIVE_LOW); d_valid = 0.
  - scan_idx = 0; wrap = 0; held select register = 0; divider = 0; state = IDLE.
- States: IDLE, DECODE, THERMO, SCAN, RSVD. State register is updated each cycle from {en, mode}.
  - en = 0 → IDLE.
  - Otherwise mode 00 → DECODE, 01 → THERMO, 10 → SCAN, 11 → RSVD.
- in_ready is combinational: 1 only when en = 1 and mode is 00 or 01 (current inputs, not state). It is independent of in_valid.
- Capture: on a rising edge with in_valid & in_ready, the held select register takes sel.
- DECODE output, latency 1 cycle from capture:
  - d[k] asserted iff k == held sel; exactly one bit asserted.
  - d_valid = 1 from the cycle after the first capture since reset, or since the last IDLE/RSVD exit. It remains 1 while in DECODE/THERMO.
- THERMO output, latency 1: d[k] asserted iff k <= held sel. sel = 0 gives only d[0]; sel = OUT_W-1 gives all bits asserted.
- DECODE ↔ THERMO switch with no new capture: d re-renders the held sel in the new format on the next cycle; d_valid stays 1.
- Without a new capture, d holds its value.
- SCAN:
  - On entry (previous state != SCAN), scan_idx and the divider are cleared to 0, and d shows one-hot index 0 on the first SCAN cycle. d_valid = 1 throughout SCAN.
  - The divider counts 0..SCAN_DIV-1. At terminal count, scan_idx increments and the divider returns to 0, so each index is held exactly SCAN_DIV cycles.
  - Wrap: scan_idx OUT_W-1 → 0, with wrap = 1 for the same cycle scan_idx reads 0.
  - SCAN_DIV = 1 means the index advances every cycle.
  - in_ready = 0; sel is ignored; the held select register is preserved.
- IDLE and RSVD:
  - d inactive and d_valid = 0 on the cycle after entry.
  - scan_idx = 0; wrap = 0; divider cleared.
  - The held select register is retained.
  - On re-entering DECODE/THERMO, d_valid stays 0 until a new capture.
- Polarity inversion is applied before the output register; d never glitches.
- Reset mid-scan: all state clears immediately; no wrap pulse is emitted.
- sel values are always in range (N bits), so there is no out-of-range handling.

Decomposition:
- Shared package decoder_pkg: mode constants MODE_DECODE = 2'b00, MODE_THERMO = 2'b01, MODE_SCAN = 2'b10, MODE_RSVD = 2'b11, plus the state encoding.
- One sub-module, scan_timer:
  - Parameters N and SCAN_DIV; inputs clk, rst_n, clear, run.
  - Outputs idx[N-1:0] and wrap.
  - Instantiated once.
- One-hot and thermometer rendering live in the top level.

Test Plan:
1. N = 3, ACTIVE_LOW = 0. Reset, then DECODE, en = 1, sel = 5 with in_valid for 1 cycle → next cycle d = 8'b0010_0000, d_valid = 1; d holds after in_valid drops.
2. DECODE with sel 3 held; switch mode to THERMO with no capture → next cycle d = 8'b0000_1111. Then capture sel = 7 → d = 8'hFF. Then sel = 0 → d = 8'h01.
3. SCAN, SCAN_DIV = 4:
   - d steps 01, 02, 04 … 80, each held 4 cycles.
   - wrap pulses once, when scan_idx returns to 0, 32 cycles after entry.
   - in_ready = 0 throughout.
4. ACTIVE_LOW = 1, DECODE, sel = 2 → d = 8'b1111_1011. Drop en → next cycle d = 8'hFF, d_valid = 0, in_ready = 0.
5. Assert rst_n = 0 asynchronously mid-SCAN at scan_idx = 6 → d, scan_idx, wrap and d_valid clear immediately without waiting for a clk edge. After release, DECODE needs a fresh capture before d_valid = 1.
6. mode = 11 while en = 1 → d inactive, d_valid = 0, in_ready = 0. Return to DECODE → d_valid stays 0 until in_valid with sel = 1 arrives, after which d = 8'h02.
